// File: rtl/booth_r16_multiplier_param.sv
// Sequential radix-16 Booth multiplier: XLEN x XLEN -> 2*XLEN product, 4 multiplier bits per cycle.
// Latency ITER = XLEN/4+1 cycles from accept to valid; ready/start handshake, clk_en stall, flush abort.
module booth_r16_multiplier_param #(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clk_en_i,
    input  logic                flush_i,
    input  logic                start_i,
    input  logic [1:0]          mode_i,
    input  logic [XLEN-1:0]     multiplicand_i,
    input  logic [XLEN-1:0]     multiplier_i,
    output logic                ready_o,
    output logic                valid_o,
    output logic [2*XLEN-1:0]   result_o
);
    localparam int ITER = XLEN / 4 + 1;
    localparam int CW   = $clog2(ITER + 1);
    localparam int BW   = XLEN + 1;
    localparam int AW   = XLEN + 4;
    localparam int PW   = XLEN + 5;
    localparam int SW   = PW + AW + 1;

    typedef enum logic [1:0] {IDLE, MULTIPLY, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  p;
    logic [AW-1:0]  a;
    logic [BW-1:0]  b;
    logic           l;

    logic [BW-1:0]  b_load;
    logic [AW-1:0]  a_load;
    logic [PW-1:0]  b1, b2, b3, b4, b5, b6, b7, b8;
    logic [PW-1:0]  mult, addend, p_sum;
    logic [3:0]     pos, mag;
    logic           neg;
    logic [SW-1:0]  sh;

    assign b_load = (mode_i == 2'b01 || mode_i == 2'b10) ? {multiplicand_i[XLEN-1], multiplicand_i}
                                                         : {1'b0, multiplicand_i};
    assign a_load = (mode_i == 2'b01) ? {{4{multiplier_i[XLEN-1]}}, multiplier_i}
                                      : {4'b0, multiplier_i};

    // Odd multiples need one adder each; even ones are shifts of a smaller multiple.
    assign b1 = {{4{b[BW-1]}}, b};
    assign b2 = b1 << 1;
    assign b3 = b1 + b2;
    assign b4 = b1 << 2;
    assign b5 = b4 + b1;
    assign b6 = b3 << 1;
    assign b8 = b1 << 3;
    assign b7 = b8 - b1;

    // Digit {A[3:0],L} = -8*A3 + 4*A2 + 2*A1 + A0 + L, split into sign and magnitude 0..8.
    assign pos = {1'b0, a[2:0]} + {3'b0, l};
    assign neg = a[3];
    assign mag = neg ? 4'd8 - pos : pos;

    always_comb begin
        mult = '0;
        case (mag)
            4'd1:    mult = b1;
            4'd2:    mult = b2;
            4'd3:    mult = b3;
            4'd4:    mult = b4;
            4'd5:    mult = b5;
            4'd6:    mult = b6;
            4'd7:    mult = b7;
            4'd8:    mult = b8;
            default: mult = '0;
        endcase
    end

    assign addend = neg ? -mult : mult;
    assign p_sum  = p + addend;
    assign sh     = $signed({p_sum, a, l}) >>> 4;

    assign ready_o = ~rst_i & clk_en_i & (state != MULTIPLY);
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            p        <= '0;
            a        <= '0;
            b        <= '0;
            l        <= 1'b0;
            result_o <= '0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            b     <= b_load;
                            a     <= a_load;
                            p     <= '0;
                            l     <= 1'b0;
                            cnt   <= '0;
                            state <= MULTIPLY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    MULTIPLY: begin
                        p   <= sh[SW-1 -: PW];
                        a   <= sh[AW:1];
                        l   <= sh[0];
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(ITER - 1)) begin
                            result_o <= sh[2*XLEN:1];
                            state    <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_booth_r16_multiplier_param.sv
// Scoreboard bench: driver pushes model products with due cycle, negedge monitor pops on valid_o.
module tb_booth_r16_multiplier_param;
    localparam int XLEN = 32;
    localparam int ITER = XLEN / 4 + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_en = 1'b1;
    logic              flush = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [XLEN-1:0]   mcand = '0;
    logic [XLEN-1:0]   mplier = '0;
    logic              ready;
    logic              valid;
    logic [2*XLEN-1:0] result;

    booth_r16_multiplier_param #(.XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .flush_i(flush), .start_i(start),
        .mode_i(mode), .multiplicand_i(mcand), .multiplier_i(mplier),
        .ready_o(ready), .valid_o(valid), .result_o(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res = '0;
    logic [63:0] last_exp = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: exact product of the extended operands, truncated to 64 bits.
    function automatic logic [63:0] model(input logic [1:0] m, input logic [31:0] bb, input logic [31:0] aa);
        logic signed [127:0] eb, ea, pr;
        eb = (m == 2'b01 || m == 2'b10) ? {{96{bb[31]}}, bb} : {96'b0, bb};
        ea = (m == 2'b01) ? {{96{aa[31]}}, aa} : {96'b0, aa};
        pr = eb * ea;
        return pr[63:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_res = '0;
        end else if (valid && clk_en) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("product", result, e.res);
                check("latency", 64'(cyc), 64'(e.due));
            end
            last_res = result;
        end else if (!valid) begin
            check("result_hold", result, last_res);
        end
    end

    task automatic issue(input logic [1:0] m, input logic [31:0] bb, input logic [31:0] aa,
                         input bit track, input int extra, input bit hold, output int k);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; mcand = bb; mplier = aa;
        for (int i = 0; i < 200; i++) begin
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("ready_timeout", 64'd0, 64'd1);
            start = 1'b0;
            k = -1;
            return;
        end
        k = cyc + 1;
        if (track) begin
            sbq.push_back('{model(m, bb, aa), k + ITER + extra});
            last_exp = model(m, bb, aa);
        end
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'(sbq.size()), 64'd0);
    endtask

    int k;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(ready), 64'd1);

        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, k);
        drain();
        check("unsigned_max", result, 64'hFFFFFFFE_00000001);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, k);
        drain();
        check("signed_m1_m1", result, 64'h00000000_00000001);
        issue(2'b01, 32'h80000000, 32'h80000000, 1, 0, 0, k);
        drain();
        check("signed_min_min", result, 64'h40000000_00000000);
        issue(2'b01, 32'h7FFFFFFF, 32'h80000000, 1, 0, 0, k);
        drain();
        check("signed_max_min", result, 64'hC0000000_80000000);
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, k);
        drain();
        check("mixed_m1_umax", result, 64'hFFFFFFFF_00000001);
        issue(2'b11, 32'hFFFFFFFF, 32'h80000001, 1, 0, 0, k);
        drain();

        for (int m = 0; m < 3; m++) begin
            for (int j = 0; j < 3; j++)
                issue(2'(m), $urandom, $urandom, 1, 0, (j < 2), k);
            drain();
        end

        for (int j = 0; j < 10; j++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom, 1, 0, 0, k);
            drain();
        end

        // Stall for 5 cycles after iteration 4.
        issue(2'b01, $urandom, $urandom, 1, 5, 0, k);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        drain();

        // Flush at iteration 6: no valid, result keeps previous product.
        issue(2'b00, $urandom, $urandom, 0, 0, 0, k);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_ready", 64'(ready), 64'd1);
        check("flush_valid", 64'(valid), 64'd0);
        check("flush_result", result, last_exp);
        repeat (ITER + 2) @(negedge clk);
        check("flush_no_late_valid", 64'(valid), 64'd0);

        // Flush wins over a coincident start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_start_idle", 64'(ready), 64'd1);
        repeat (ITER + 2) @(negedge clk);
        check("flush_start_no_valid", 64'(valid), 64'd0);

        // Asynchronous reset mid-multiply.
        issue(2'b01, $urandom, $urandom, 0, 0, 0, k);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(valid), 64'd0);
        check("async_rst_result", result, 64'd0);
        check("async_rst_ready", 64'(ready), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        issue(2'b00, 32'd3, 32'd5, 1, 0, 0, k);
        drain();
        check("three_x_five", result, 64'd15);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_r16_multiplier_param.md
# booth_r16_multiplier_param

Parametrised sequential radix-16 Booth multiplier, successor to the fixed 32-bit FPU mantissa multiplier. It adds a generic operand width, three signedness modes (unsigned, signed, signed×unsigned) for shared use by the integer M-unit and the FPU, and a ready/start handshake. It also adds a synchronous flush for pipeline kills and back-to-back operation. It retires 4 multiplier bits per cycle and produces the full double-width product.

## Interface
- XLEN, 32, operand width; multiple of 4, >= 8
- ITER, XLEN/4 + 1, derived localparam: number of iterations (latency in cycles)
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- clk_en_i  input  1  global stall; when low, all registers hold
- flush_i  input  1  synchronous abort of any in-flight operation
- start_i  input  1  operands valid; accepted when start_i & ready_o at a rising edge
- mode_i  input  2  00 unsigned×unsigned, 01 signed×signed, 10 multiplicand signed × multiplier unsigned, 11 treated as 00
- multiplicand_i  input  XLEN  operand B
- multiplier_i  input  XLEN  operand A
- ready_o  output  1  can accept operands this cycle
- valid_o  output  1  result_o holds a fresh product
- result_o  output  2*XLEN  low 2*XLEN bits of the exact product

## Operation
- FSM states:
  - IDLE: ready_o = clk_en_i.
  - MULTIPLY: ready_o = 0.
  - DONE: valid_o = 1, ready_o = clk_en_i.
- Transitions (only when clk_en_i = 1; flush_i has top priority):
  - flush_i from any state -> IDLE. Counter is cleared, result_o is unchanged, and no valid_o is produced.
  - IDLE or DONE with start_i -> MULTIPLY, with operands loaded.
  - DONE without start_i -> IDLE.
  - MULTIPLY with counter == ITER-1 -> DONE.
- Operand load:
  - B is extended to XLEN+1 bits: sign-extended in modes 01/10, zero-extended otherwise.
  - A is extended to XLEN+4 bits: sign-extended in mode 01, zero-extended otherwise.
  - P register (XLEN+5 bits) <= 0, L <= 0, counter <= 0.
  - Operands are captured at acceptance. Later input changes are ignored.
- Iteration:
  - The digit {A[3:0], L} selects the signed multiple -8B..+8B, using standard radix-16 Booth recoding. 00000/11111 select 0.
  - P is sized so that ±8B never overflows.
  - {P', A, L} is arithmetically shifted right by 4.
  - counter increments by 1.
- Final iteration:
  - result_o is loaded with the low 2*XLEN bits of the shifted {P', A} (excluding L), at the same edge the FSM enters DONE.
  - result_o then holds until the next completion.
- Arithmetic rule: result_o equals (ext(B) × ext(A)) mod 2^(2*XLEN), exact for every operand value in every mode.
- Stall: clk_en_i = 0 freezes the state, counter, datapath and result_o. valid_o stays high if the block is stalled in DONE. start_i and flush_i are ignored while stalled.

## Timing
- Reset values: state IDLE, ready_o = 0 while rst_i is high, then 1 (with clk_en_i = 1). valid_o = 0, result_o = 0, counter = 0, P/A/B/L = 0.
- Reset mid-operation: the block returns to IDLE immediately. No valid_o and no partial result appear.
- Latency: operands accepted at edge k -> valid_o high from edge k+ITER to k+ITER+1 (one cycle, absent stalls). For XLEN=32, ITER = 9.
- Throughput:
  - start_i held high in DONE gives a new operation every ITER+1 cycles.
  - The old result stays on result_o through the MULTIPLY phase of the next operation.
- Flush coincident with start_i: flush wins, the operands are not accepted, and the next state is IDLE.
- Flush coincident with the final iteration: the state goes to IDLE, result_o is not updated, and valid_o stays 0.
- Combinational paths:
  - ready_o depends on state and clk_en_i only.
  - No input-to-output path exists on result_o or valid_o.

## Test plan
All scenarios use XLEN = 32.
- Unsigned: mode 00, B = A = 0xFFFFFFFF -> after 9 cycles valid_o pulses once and result_o = 0xFFFFFFFE_00000001.
- Signed corners:
  - mode 01, -1 × -1 -> 0x00000000_00000001.
  - 0x80000000 × 0x80000000 -> 0x40000000_00000000.
  - 0x7FFFFFFF × 0x80000000 -> 0xC0000000_80000000.
- Mixed: mode 10, B = 0xFFFFFFFF (-1), A = 0xFFFFFFFF (unsigned) -> 0xFFFFFFFF_00000001.
- Back-to-back: start_i held high with 3 random operand pairs per mode -> valid_o at cycles 9, 19, 29 after the first accept, each product matching the reference model. result_o holds between pulses.
- Stall and flush:
  - Operation with clk_en_i low for 5 cycles at iteration 4 -> valid_o at cycle 14.
  - flush_i at iteration 6 -> no valid_o, result_o unchanged, ready_o high next cycle.
- Reset: rst_i asserted asynchronously mid-MULTIPLY (between edges) -> outputs zero immediately. After release, a new 3 × 5 unsigned operation returns 15.
